// File: rtl/cp0_exception_ctrl.sv
// cp0_exception_ctrl: MEM-side exception entry / ERET sequencer.
// Drives the CP0 write vector, pipeline flush and PC redirect.
module cp0_exception_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid,
   input  logic [31:0] pc_m,
   input  logic        in_delay_slot,
   input  logic        adel_if,
   input  logic        ri,
   input  logic        ov,
   input  logic        syscall,
   input  logic        brk,
   input  logic        adel_ld,
   input  logic        ades_st,
   input  logic [31:0] mem_addr,
   input  logic        eret,
   input  logic        status_ie,
   input  logic        status_exl,
   input  logic [7:0]  status_im,
   input  logic [5:0]  hw_int,
   input  logic [1:0]  sw_int,
   input  logic [31:0] epc_cur,
   output logic [31:0] we,
   output logic [4:0]  Exception_code,
   output logic        EXL,
   output logic [31:0] epc,
   output logic [31:0] BADADDR,
   output logic        Branch_delay,
   output logic [5:0]  hardware_interruption,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, COMMIT, ERET_C, FLUSH} state_t;

   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

   state_t                       state_q, state_d;
   logic [2:0]                   cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0][5:0]  sync_q;
   logic                         addr_q;

   logic        int_req;
   logic        exc_hit;
   logic        addr_exc;
   logic [4:0]  exc_code;
   logic [31:0] exc_bad;
   logic        take_exc;
   logic        take_eret;

   assign hardware_interruption = sync_q[SYNC_STAGES-1];

   assign int_req = inst_valid & status_ie & ~status_exl &
                    (|({hardware_interruption, sw_int} & status_im));

   always_comb begin
      exc_hit  = 1'b1;
      addr_exc = 1'b0;
      exc_code = 5'h00;
      exc_bad  = '0;
      priority case (1'b1)
         int_req:              exc_code = 5'h00;
         inst_valid & adel_if: begin
            exc_code = 5'h04;
            addr_exc = 1'b1;
            exc_bad  = pc_m;
         end
         inst_valid & ri:      exc_code = 5'h0A;
         inst_valid & ov:      exc_code = 5'h0C;
         inst_valid & syscall: exc_code = 5'h08;
         inst_valid & brk:     exc_code = 5'h09;
         inst_valid & adel_ld: begin
            exc_code = 5'h04;
            addr_exc = 1'b1;
            exc_bad  = mem_addr;
         end
         inst_valid & ades_st: begin
            exc_code = 5'h05;
            addr_exc = 1'b1;
            exc_bad  = mem_addr;
         end
         default:              exc_hit = 1'b0;
      endcase
   end

   // sources are only honoured in IDLE; everything else is being flushed
   assign take_exc  = (state_q == IDLE) & exc_hit;
   assign take_eret = (state_q == IDLE) & ~exc_hit & eret & inst_valid;
   assign busy      = (state_q != IDLE);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      we             = '0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      unique case (state_q)
         IDLE: begin
            if (take_exc)       state_d = COMMIT;
            else if (take_eret) state_d = ERET_C;
         end
         COMMIT: begin
            we             = {17'b0, 3'b111, 3'b0, addr_q, 8'b0};
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = EXC_VECTOR;
            cnt_d          = 3'd1;
            state_d        = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
         end
         ERET_C: begin
            we             = 32'h0000_1000;
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = epc_cur;
            cnt_d          = 3'd1;
            state_d        = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
         end
         FLUSH: begin
            flush = 1'b1;
            if (cnt_q >= FLUSH_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         sync_q         <= '0;
         addr_q         <= 1'b0;
         Exception_code <= '0;
         EXL            <= 1'b0;
         epc            <= '0;
         BADADDR        <= '0;
         Branch_delay   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], hw_int};
         if (take_exc) begin
            addr_exc_cap: begin
               addr_q         <= addr_exc;
               Exception_code <= exc_code;
               EXL            <= 1'b1;
               epc            <= in_delay_slot ? pc_m - 32'd4 : pc_m;
               BADADDR        <= exc_bad;
               Branch_delay   <= in_delay_slot;
            end
         end else if (take_eret) begin
            EXL <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// tb_cp0_exception_ctrl: directed scenarios plus randomized run
// against a cycle-level behavioural model of exception entry.
module tb_cp0_exception_ctrl;

   localparam logic [31:0] VEC = 32'hBFC00380;
   localparam int          FC  = 2;
   localparam int          SS  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_valid, in_delay_slot;
   logic [31:0] pc_m, mem_addr, epc_cur;
   logic        adel_if, ri, ov, syscall, brk, adel_ld, ades_st, eret;
   logic        status_ie, status_exl;
   logic [7:0]  status_im;
   logic [5:0]  hw_int;
   logic [1:0]  sw_int;

   logic [31:0] we, epc, BADADDR, redirect_pc;
   logic [4:0]  Exception_code;
   logic        EXL, Branch_delay, flush, redirect_valid, busy;
   logic [5:0]  hardware_interruption;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cp0_exception_ctrl #(
      .EXC_VECTOR  (VEC),
      .FLUSH_CYCLES(FC),
      .SYNC_STAGES (SS)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .inst_valid           (inst_valid),
      .pc_m                 (pc_m),
      .in_delay_slot        (in_delay_slot),
      .adel_if              (adel_if),
      .ri                   (ri),
      .ov                   (ov),
      .syscall              (syscall),
      .brk                  (brk),
      .adel_ld              (adel_ld),
      .ades_st              (ades_st),
      .mem_addr             (mem_addr),
      .eret                 (eret),
      .status_ie            (status_ie),
      .status_exl           (status_exl),
      .status_im            (status_im),
      .hw_int               (hw_int),
      .sw_int               (sw_int),
      .epc_cur              (epc_cur),
      .we                   (we),
      .Exception_code       (Exception_code),
      .EXL                  (EXL),
      .epc                  (epc),
      .BADADDR              (BADADDR),
      .Branch_delay         (Branch_delay),
      .hardware_interruption(hardware_interruption),
      .flush                (flush),
      .redirect_valid       (redirect_valid),
      .redirect_pc          (redirect_pc),
      .busy                 (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inst_valid    = 1'b0;
      in_delay_slot = 1'b0;
      pc_m          = '0;
      mem_addr      = '0;
      epc_cur       = '0;
      adel_if       = 1'b0;
      ri            = 1'b0;
      ov            = 1'b0;
      syscall       = 1'b0;
      brk           = 1'b0;
      adel_ld       = 1'b0;
      ades_st       = 1'b0;
      eret          = 1'b0;
      status_ie     = 1'b1;
      status_exl    = 1'b0;
      status_im     = '0;
      hw_int        = '0;
      sw_int        = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst        = 1'b0;
      hw_int     = 6'h3F;
      inst_valid = 1'b1;
      ov         = 1'b1;
      repeat (3) step();
      checks++;
      if ({we, Exception_code, EXL, epc, BADADDR, Branch_delay,
           hardware_interruption, flush, redirect_valid,
           redirect_pc, busy} !== '0)
         begin
            errors++;
            $display("FAIL reset_outputs: we=%h code=%h hwi=%h busy=%b want all 0",
                     we, Exception_code, hardware_interruption, busy);
         end
      clear_inputs();
      rst = 1'b1;
      step();
      checks++;
      if ({busy, flush, hardware_interruption} !== '0) begin
         errors++;
         $display("FAIL reset_release: busy=%b flush=%b hwi=%h want 0",
                  busy, flush, hardware_interruption);
      end
   endtask

   task automatic test_ov();
      clear_inputs();
      inst_valid = 1'b1;
      ov         = 1'b1;
      pc_m       = 32'h8000_0100;
      step();
      checks++;
      if (we !== 32'h0000_7000 || Exception_code !== 5'h0C || EXL !== 1'b1) begin
         errors++;
         $display("FAIL ov_commit: we=%h code=%h exl=%b want 00007000 0c 1",
                  we, Exception_code, EXL);
      end
      checks++;
      if (epc !== 32'h8000_0100 || Branch_delay !== 1'b0 || BADADDR !== 32'h0) begin
         errors++;
         $display("FAIL ov_epc: epc=%h bd=%b bad=%h want 80000100 0 0",
                  epc, Branch_delay, BADADDR);
      end
      checks++;
      if ({redirect_valid, redirect_pc, flush, busy} !== {1'b1, VEC, 2'b11}) begin
         errors++;
         $display("FAIL ov_redirect: rv=%b rpc=%h flush=%b busy=%b want 1 %h 1 1",
                  redirect_valid, redirect_pc, flush, busy, VEC);
      end
      clear_inputs();
      step();
      checks++;
      if ({flush, busy, redirect_valid} !== 3'b110 || we !== 32'h0 ||
          Exception_code !== 5'h0C) begin
         errors++;
         $display("FAIL ov_flush: flush=%b busy=%b rv=%b we=%h code=%h want 1 1 0 0 0c",
                  flush, busy, redirect_valid, we, Exception_code);
      end
      step();
      checks++;
      if ({flush, busy} !== 2'b00) begin
         errors++;
         $display("FAIL ov_idle: flush=%b busy=%b want 0 0", flush, busy);
      end
   endtask

   task automatic test_adel_ld();
      clear_inputs();
      inst_valid    = 1'b1;
      adel_ld       = 1'b1;
      mem_addr      = 32'h0000_0003;
      pc_m          = 32'hBFC0_0010;
      in_delay_slot = 1'b1;
      step();
      checks++;
      if (we !== 32'h0000_7100 || Exception_code !== 5'h04 ||
          BADADDR !== 32'h3 || epc !== 32'hBFC0_000C || Branch_delay !== 1'b1) begin
         errors++;
         $display("FAIL adel_ld: we=%h code=%h bad=%h epc=%h bd=%b want 00007100 04 3 bfc0000c 1",
                  we, Exception_code, BADADDR, epc, Branch_delay);
      end
      clear_inputs();
      repeat (FC) step();
   endtask

   task automatic test_adel_if_wrap();
      clear_inputs();
      inst_valid    = 1'b1;
      adel_if       = 1'b1;
      ri            = 1'b1;
      ov            = 1'b1;
      mem_addr      = 32'h1111_1111;
      pc_m          = 32'h0;
      in_delay_slot = 1'b1;
      step();
      checks++;
      if (we !== 32'h0000_7100 || Exception_code !== 5'h04 ||
          BADADDR !== 32'h0 || epc !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL adel_if_wrap: we=%h code=%h bad=%h epc=%h want 00007100 04 0 fffffffc",
                  we, Exception_code, BADADDR, epc);
      end
      clear_inputs();
      repeat (FC) step();
   endtask

   task automatic test_interrupt();
      clear_inputs();
      status_im = 8'h04;
      hw_int    = 6'h01;
      step();
      hw_int = 6'h00;
      repeat (SS - 2) step();
      checks++;
      if (hardware_interruption !== 6'h00) begin
         errors++;
         $display("FAIL int_sync_early: hwi=%h want 00", hardware_interruption);
      end
      step();
      checks++;
      if (hardware_interruption !== 6'h01 || busy !== 1'b0) begin
         errors++;
         $display("FAIL int_sync: hwi=%h busy=%b want 01 0",
                  hardware_interruption, busy);
      end
      inst_valid = 1'b1;
      syscall    = 1'b1;
      pc_m       = 32'h8000_0300;
      step();
      checks++;
      if (Exception_code !== 5'h00 || we !== 32'h0000_7000 ||
          epc !== 32'h8000_0300 || BADADDR !== 32'h0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL int_wins: code=%h we=%h epc=%h bad=%h busy=%b want 00 00007000 80000300 0 1",
                  Exception_code, we, epc, BADADDR, busy);
      end
      clear_inputs();
      repeat (FC) step();
   endtask

   task automatic test_int_exl_masked();
      clear_inputs();
      status_im  = 8'h04;
      status_exl = 1'b1;
      inst_valid = 1'b1;
      hw_int     = 6'h01;
      for (int i = 0; i < SS + 3; i++) begin
         step();
         checks++;
         if (busy !== 1'b0 || we !== 32'h0) begin
            errors++;
            $display("FAIL int_exl_masked: cycle=%0d busy=%b we=%h want 0 0",
                     i, busy, we);
         end
      end
      checks++;
      if (hardware_interruption !== 6'h01) begin
         errors++;
         $display("FAIL int_exl_pending: hwi=%h want 01", hardware_interruption);
      end
      inst_valid = 1'b0;
      hw_int     = 6'h00;
      repeat (SS + 1) step();
      clear_inputs();
   endtask

   task automatic test_eret();
      clear_inputs();
      inst_valid = 1'b1;
      eret       = 1'b1;
      epc_cur    = 32'h8000_0200;
      step();
      checks++;
      if (we !== 32'h0000_1000 || EXL !== 1'b0 || redirect_valid !== 1'b1 ||
          redirect_pc !== 32'h8000_0200 || {flush, busy} !== 2'b11) begin
         errors++;
         $display("FAIL eret: we=%h exl=%b rv=%b rpc=%h flush=%b busy=%b want 00001000 0 1 80000200 1 1",
                  we, EXL, redirect_valid, redirect_pc, flush, busy);
      end
      clear_inputs();
      repeat (FC) step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL eret_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_eret_vs_ri();
      clear_inputs();
      inst_valid = 1'b1;
      eret       = 1'b1;
      ri         = 1'b1;
      pc_m       = 32'h8000_0400;
      epc_cur    = 32'h1234_5678;
      step();
      checks++;
      if (Exception_code !== 5'h0A || we !== 32'h0000_7000 || EXL !== 1'b1 ||
          redirect_pc !== VEC) begin
         errors++;
         $display("FAIL eret_vs_ri: code=%h we=%h exl=%b rpc=%h want 0a 00007000 1 %h",
                  Exception_code, we, EXL, redirect_pc, VEC);
      end
      clear_inputs();
      step();
      checks++;
      if (we !== 32'h0 || redirect_valid !== 1'b0 || EXL !== 1'b1) begin
         errors++;
         $display("FAIL eret_vs_ri_flush: we=%h rv=%b exl=%b want 0 0 1",
                  we, redirect_valid, EXL);
      end
      step();
   endtask

   task automatic test_reset_mid_flush();
      clear_inputs();
      inst_valid = 1'b1;
      brk        = 1'b1;
      pc_m       = 32'h8000_0500;
      step();
      clear_inputs();
      step();
      checks++;
      if (busy !== 1'b1 || flush !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: busy=%b flush=%b want 1 1", busy, flush);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({we, Exception_code, EXL, epc, BADADDR, Branch_delay,
           hardware_interruption, flush, redirect_valid,
           redirect_pc, busy} !== '0)
         begin
            errors++;
            $display("FAIL rst_mid_async: busy=%b flush=%b code=%h epc=%h exl=%b want all 0",
                     busy, flush, Exception_code, epc, EXL);
         end
      #2 rst = 1'b1;
      step();
      checks++;
      if ({busy, flush, we} !== '0) begin
         errors++;
         $display("FAIL rst_mid_release: busy=%b flush=%b we=%h want 0 0 0",
                  busy, flush, we);
      end
   endtask

   task automatic test_brk_in_flush();
      clear_inputs();
      inst_valid = 1'b1;
      ov         = 1'b1;
      pc_m       = 32'h8000_0600;
      step();
      clear_inputs();
      step();
      inst_valid = 1'b1;
      brk        = 1'b1;
      step();
      clear_inputs();
      checks++;
      if (busy !== 1'b0 || we !== 32'h0 || Exception_code !== 5'h0C) begin
         errors++;
         $display("FAIL brk_in_flush: busy=%b we=%h code=%h want 0 0 0c",
                  busy, we, Exception_code);
      end
   endtask

   task automatic test_random(input int n);
      logic [5:0]  h [SS];
      int          busy_left;
      int          kind;
      logic [4:0]  m_code, t_code;
      logic        m_exl, m_bd, m_addr, t_addr;
      logic [31:0] m_epc, m_bad, t_bad, exp_we, exp_rpc;
      logic        irq, hit;

      clear_inputs();
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int i = 0; i < SS; i++) h[i] = '0;
      busy_left = 0;
      kind      = 0;
      m_code    = '0;
      m_exl     = 1'b0;
      m_bd      = 1'b0;
      m_addr    = 1'b0;
      m_epc     = '0;
      m_bad     = '0;

      for (int c = 0; c < n; c++) begin
         exp_we  = (kind == 1) ? (32'h7000 | (m_addr ? 32'h100 : 32'h0)) :
                   (kind == 2) ? 32'h1000 : 32'h0;
         exp_rpc = (kind == 1) ? VEC : (kind == 2) ? epc_cur : 32'h0;
         checks++;
         if (we !== exp_we) begin
            errors++;
            $display("FAIL rnd_we: cyc=%0d got %h want %h", c, we, exp_we);
         end
         checks++;
         if ({Exception_code, EXL, Branch_delay} !== {m_code, m_exl, m_bd}) begin
            errors++;
            $display("FAIL rnd_fields: cyc=%0d code/exl/bd got %h/%b/%b want %h/%b/%b",
                     c, Exception_code, EXL, Branch_delay, m_code, m_exl, m_bd);
         end
         checks++;
         if (epc !== m_epc || BADADDR !== m_bad) begin
            errors++;
            $display("FAIL rnd_epc_bad: cyc=%0d got %h/%h want %h/%h",
                     c, epc, BADADDR, m_epc, m_bad);
         end
         checks++;
         if ({redirect_valid, redirect_pc} !== {kind != 0, exp_rpc}) begin
            errors++;
            $display("FAIL rnd_redirect: cyc=%0d got %b/%h want %b/%h",
                     c, redirect_valid, redirect_pc, kind != 0, exp_rpc);
         end
         checks++;
         if ({flush, busy} !== {busy_left > 0, busy_left > 0}) begin
            errors++;
            $display("FAIL rnd_busy: cyc=%0d flush/busy got %b/%b want %0d left",
                     c, flush, busy, busy_left);
         end
         checks++;
         if (hardware_interruption !== h[SS-1]) begin
            errors++;
            $display("FAIL rnd_hwi: cyc=%0d got %h want %h",
                     c, hardware_interruption, h[SS-1]);
         end

         inst_valid    = ($urandom_range(0, 3) != 0);
         in_delay_slot = $urandom_range(0, 1) == 1;
         pc_m          = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom & ~32'd3);
         mem_addr      = $urandom;
         epc_cur       = $urandom;
         adel_if       = ($urandom_range(0, 15) == 0);
         ri            = ($urandom_range(0, 15) == 0);
         ov            = ($urandom_range(0, 15) == 0);
         syscall       = ($urandom_range(0, 15) == 0);
         brk           = ($urandom_range(0, 15) == 0);
         adel_ld       = ($urandom_range(0, 15) == 0);
         ades_st       = ($urandom_range(0, 15) == 0);
         eret          = ($urandom_range(0, 7) == 0);
         status_ie     = $urandom_range(0, 1) == 1;
         status_exl    = ($urandom_range(0, 3) == 0);
         status_im     = 8'($urandom);
         hw_int        = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h0;
         sw_int        = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'h0;

         if (busy_left > 0) begin
            busy_left--;
            kind = 0;
         end else begin
            irq = inst_valid && status_ie && !status_exl &&
                  (({h[SS-1], sw_int} & status_im) != 8'h0);
            hit    = 1'b1;
            t_addr = 1'b0;
            t_bad  = 32'h0;
            t_code = 5'h00;
            if (irq)                 t_code = 5'h00;
            else if (!inst_valid)    hit = 1'b0;
            else if (adel_if) begin
               t_code = 5'h04; t_addr = 1'b1; t_bad = pc_m;
            end
            else if (ri)             t_code = 5'h0A;
            else if (ov)             t_code = 5'h0C;
            else if (syscall)        t_code = 5'h08;
            else if (brk)            t_code = 5'h09;
            else if (adel_ld) begin
               t_code = 5'h04; t_addr = 1'b1; t_bad = mem_addr;
            end
            else if (ades_st) begin
               t_code = 5'h05; t_addr = 1'b1; t_bad = mem_addr;
            end
            else                     hit = 1'b0;

            if (hit) begin
               kind      = 1;
               busy_left = FC;
               m_code    = t_code;
               m_addr    = t_addr;
               m_bad     = t_bad;
               m_exl     = 1'b1;
               m_bd      = in_delay_slot;
               m_epc     = in_delay_slot ? pc_m - 32'd4 : pc_m;
            end else if (inst_valid && eret) begin
               kind      = 2;
               busy_left = FC;
               m_exl     = 1'b0;
            end else begin
               kind = 0;
            end
         end
         for (int i = SS - 1; i > 0; i--) h[i] = h[i-1];
         h[0] = hw_int;
         step();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_ov();
      test_adel_ld();
      test_adel_if_wrap();
      test_interrupt();
      test_int_exl_masked();
      test_eret();
      test_eret_vs_ri();
      test_reset_mid_flush();
      test_brk_in_flush();
      test_random(3000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
